// File: rtl/color_batch_scheduler_if.sv
// Transmit-side valid/ready handshake between the colour batch scheduler
// and the downstream SPI matrix transmitter.
interface color_batch_scheduler_if #(
    parameter int BATCH_SIZE = 8,
    parameter int NUM_CH     = 3
);
    localparam int DW = 8 * BATCH_SIZE;
    localparam int CW = $clog2(NUM_CH);

    logic          O_tx_valid;
    logic [DW-1:0] O_tx_data;
    logic [CW-1:0] O_tx_channel;
    logic          I_tx_ready;

    modport master (
        output O_tx_valid,
        output O_tx_data,
        output O_tx_channel,
        input  I_tx_ready
    );

    modport slave (
        input  O_tx_valid,
        input  O_tx_data,
        input  O_tx_channel,
        output I_tx_ready
    );
endinterface

// File: rtl/color_batch_scheduler.sv
// Captures per-channel colour batches and arbitrates them onto one tx port.
// COLOR_BATCH_SCHED_STRICT_ORDER_EN selects strict 0,1,..,NUM_CH-1 ordering.
module color_batch_scheduler #(
    parameter int BATCH_SIZE = 8,
    parameter int NUM_CH     = 3
) (
    input  logic                         I_rgb_clk,
    input  logic                         I_rst,
    input  logic [NUM_CH-1:0]            I_batch_ready,
    input  logic [NUM_CH*8*BATCH_SIZE-1:0] I_batch_color,
    input  logic                         I_clear_overflow,
    output logic [NUM_CH-1:0]            O_overflow,
    color_batch_scheduler_if.master      tx
);
    localparam int DW = 8 * BATCH_SIZE;
    localparam int CW = $clog2(NUM_CH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [DW-1:0]     data_q, data_d;
    logic [CW-1:0]     ch_q, ch_d;
    logic [DW-1:0]     hold_q [NUM_CH];

    logic [CW-1:0]     sel;
    logic              found;
    logic              load;
    logic              grant;
    logic [NUM_CH-1:0] gnt_vec;

`ifdef COLOR_BATCH_SCHED_STRICT_ORDER_EN
    logic [CW-1:0] exp_q, exp_d;

    always_comb begin
        sel   = exp_q;
        found = pend_q[exp_q];
    end

    always_comb begin
        exp_d = exp_q;
        if (grant)
            exp_d = (exp_q == CW'(NUM_CH - 1)) ? '0 : exp_q + CW'(1);
    end
`else
    logic [CW-1:0] last_q, last_d;
    logic [CW-1:0] idx;

    // First pending channel after the last grant, wrapping modulo NUM_CH.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = CW'((int'(last_q) + i) % NUM_CH);
            if (!found && pend_q[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign last_d = grant ? sel : last_q;
`endif

    assign load    = (state_q == IDLE) || tx.I_tx_ready;
    assign grant   = load && found;
    assign gnt_vec = grant ? (NUM_CH'(1) << sel) : '0;

    // A same-edge grant frees the slot, so a recapture is not an overrun.
    assign pend_d = I_batch_ready | (pend_q & ~gnt_vec);
    assign ovf_d  = I_clear_overflow ? '0
                  : ovf_q | (I_batch_ready & pend_q & ~gnt_vec);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        if (grant) begin
            state_d = SEND;
            data_d  = hold_q[sel];
            ch_d    = sel;
        end else if (load) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge I_rgb_clk) begin
        for (int c = 0; c < NUM_CH; c++)
            if (I_batch_ready[c])
                hold_q[c] <= I_batch_color[c*DW +: DW];
    end

    always_ff @(posedge I_rgb_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            ovf_q   <= '0;
            data_q  <= '0;
            ch_q    <= '0;
`ifdef COLOR_BATCH_SCHED_STRICT_ORDER_EN
            exp_q   <= '0;
`else
            last_q  <= CW'(NUM_CH - 1);
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
`ifdef COLOR_BATCH_SCHED_STRICT_ORDER_EN
            exp_q   <= exp_d;
`else
            last_q  <= last_d;
`endif
        end
    end

    assign tx.O_tx_valid   = (state_q == SEND);
    assign tx.O_tx_data    = data_q;
    assign tx.O_tx_channel = ch_q;
    assign O_overflow      = ovf_q;
endmodule

// File: doc/color_batch_scheduler.md
Name: color_batch_scheduler

Overview:
Sits between the per-channel colour batch buffers (R, G, B) and the single downstream SPI matrix transmitter. It captures each channel's completed batch into a holding register on that channel's ready pulse. It then arbitrates the held batches round-robin onto one valid/ready transmit port and flags batches lost to overrun.

Parameters:
BATCH_SIZE, 8, bytes per batch; each channel's batch bus is 8*BATCH_SIZE bits.
NUM_CH, 3, number of colour channels (requesters); must be >= 2.

Ports:
I_rgb_clk  in  1  system clock; all logic rising-edge.
I_rst  in  1  asynchronous, active-high reset.
I_batch_ready  in  NUM_CH  per-channel 1-cycle pulse: batch on I_batch_color slice is complete.
I_batch_color  in  NUM_CH*8*BATCH_SIZE  channel c occupies bits [c*8*BATCH_SIZE +: 8*BATCH_SIZE].
O_tx_valid  out  1  output batch valid.
O_tx_data  out  8*BATCH_SIZE  batch payload, registered.
O_tx_channel  out  $clog2(NUM_CH)  channel index of O_tx_data.
I_tx_ready  in  1  downstream accepts when O_tx_valid && I_tx_ready at a rising edge.
O_overflow  out  NUM_CH  sticky per-channel overrun flags.
I_clear_overflow  in  1  synchronous clear of all O_overflow bits.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - O_tx_valid=0, O_tx_data=0, O_tx_channel=0, O_overflow=0.
  - All pending flags clear; holding registers need no reset.
  - Round-robin pointer last_grant=NUM_CH-1, so channel 0 wins first.
- Capture: on an edge with I_batch_ready[c]=1:
  - hold[c] <= slice c; pending[c] <= 1.
  - If pending[c] was already 1 and channel c is not granted that same edge, the old batch is overwritten and O_overflow[c] <= 1.
- Simultaneous capture and grant of the same channel:
  - The old hold[c] goes to the output register.
  - The new data is captured, pending[c] stays 1, no overflow.
- I_clear_overflow takes priority over a same-cycle overflow set (clear wins).
- FSM states: IDLE, SEND.
  - IDLE, some pending bit set: pick the first pending channel searching from last_grant+1 with wrap modulo NUM_CH. Load O_tx_data=hold[sel], O_tx_channel=sel, O_tx_valid=1, clear pending[sel], set last_grant=sel, go to SEND.
  - IDLE, nothing pending: stay; O_tx_valid=0.
  - SEND, no handshake: O_tx_valid, O_tx_data and O_tx_channel held stable (valid never drops without a handshake).
  - SEND, handshake with another channel pending: load the next grant on the same edge (back-to-back, no bubble) and stay in SEND.
  - SEND, handshake with nothing pending: O_tx_valid <= 0, go to IDLE.
- Arbitration sees pending bits as registered at the current edge. A batch captured on edge N is eligible at edge N+1, giving O_tx_valid high after edge N+1 at minimum latency (2 edges from the I_batch_ready sample).
- Several I_batch_ready bits may pulse together; all are captured.
- Throughput: one batch per cycle when I_tx_ready is held high.
- Reset mid-SEND drops the in-flight batch and all pending batches; no partial state survives.

Optional Feature:
Macro COLOR_BATCH_SCHED_STRICT_ORDER_EN.
- Defined: round-robin is replaced by strict cyclic order 0,1,...,NUM_CH-1,0.
  - Only channel expected_ch may be granted; the scheduler waits in IDLE while other channels are pending.
  - expected_ch resets to 0 and advances, with wrap, on each grant.
  - This guarantees R,G,B framing to the transmitter.
- Undefined: work-conserving round-robin as above; no expected_ch register.

Test Plan:
- Single batch: after reset, pulse I_batch_ready=3'b001 with ch0 data 64'h0706050403020100, I_tx_ready=1 -> O_tx_valid high exactly one cycle, 2 edges after the pulse, with O_tx_channel=0 and that data; O_overflow=0.
- Simultaneous requests: pulse 3'b111 with distinct data, I_tx_ready=1 -> three consecutive valid cycles, channels 0,1,2, no bubble.
- Backpressure: hold I_tx_ready=0 for 10 cycles with ch1 pending -> O_tx_valid/data/channel stable all 10 cycles. Raise ready -> one transfer, then valid=0.
- Overflow: I_tx_ready=0, ch2 pending and in SEND as ch0, pulse ch2 again with new data -> O_overflow=3'b100 and ch2 later transmits the newer data. Pulse I_clear_overflow -> 0.
- Round-robin fairness: keep ch0 and ch2 re-requesting every cycle, ready=1 -> grants alternate 0,2,0,2. With the macro defined, ch2 requests alone -> no grant until ch0 and then ch1 have been granted.
- Reset mid-operation: assert I_rst while O_tx_valid=1 with two pending -> outputs 0 immediately. After release, no transfer occurs until a new I_batch_ready.
